// File: rtl/ex_hazard_controller.sv
// EX-stage hazard sequencer: slot tracking, operand forwarding, load-use and multi-cycle stalls.
// Optional WB-slot bypass (select 11) is built only when WB_BYPASS_EN is defined.
module ex_hazard_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_rs1_used,
  input  logic       dec_rs2_used,
  input  logic [4:0] RW_dec,
  input  logic       dec_wr_en,
  input  logic       dec_is_load,
  input  logic       dec_multi,
  input  logic       flush,
  output logic       issue,
  output logic       stall,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       ex_busy
);

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
`ifdef WB_BYPASS_EN
  localparam logic [1:0] SEL_WB  = 2'b11;
`endif

  typedef struct packed {
    logic [REG_W-1:0] rw;
    logic             wr;
    logic             load;
  } ex_slot_t;

  typedef struct packed {
    logic [REG_W-1:0] rw;
    logic             wr;
  } slot_t;

  typedef enum logic {RUN, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ex_slot_t         ex_q, ex_d;
  slot_t            mem_q, mem_d;
`ifdef WB_BYPASS_EN
  slot_t            wb_q, wb_d;
`endif

  // R0 never matches: it is hardwired zero in the register file.
  function automatic logic src_match(input logic used, input logic [REG_W-1:0] src,
                                     input logic wr, input logic [REG_W-1:0] rw);
    return used && (src != REG_W'(0)) && wr && (rw == src);
  endfunction

  logic ma_ex_c, mb_ex_c, ma_mem_c, mb_mem_c;
  logic load_use_c;
  logic [1:0] a_sel_c, b_sel_c;

  assign ma_ex_c  = src_match(dec_rs1_used, dec_rs1, ex_q.wr,  ex_q.rw);
  assign mb_ex_c  = src_match(dec_rs2_used, dec_rs2, ex_q.wr,  ex_q.rw);
  assign ma_mem_c = src_match(dec_rs1_used, dec_rs1, mem_q.wr, mem_q.rw);
  assign mb_mem_c = src_match(dec_rs2_used, dec_rs2, mem_q.wr, mem_q.rw);

`ifdef WB_BYPASS_EN
  logic ma_wb_c, mb_wb_c;
  assign ma_wb_c  = src_match(dec_rs1_used, dec_rs1, wb_q.wr, wb_q.rw);
  assign mb_wb_c  = src_match(dec_rs2_used, dec_rs2, wb_q.wr, wb_q.rw);
`endif

  // Load data is not ready in EX; it resolves one cycle later from MEM.
  assign load_use_c = dec_valid && ex_q.load && (ma_ex_c || mb_ex_c);

  // Operand source selection, youngest producer first.
  always_comb begin
    a_sel_c = SEL_RF;
    if (ma_ex_c && !ex_q.load)      a_sel_c = SEL_EX;
    else if (ma_mem_c)              a_sel_c = SEL_MEM;
`ifdef WB_BYPASS_EN
    else if (ma_wb_c)               a_sel_c = SEL_WB;
`endif
  end

  always_comb begin
    b_sel_c = SEL_RF;
    if (mb_ex_c && !ex_q.load)      b_sel_c = SEL_EX;
    else if (mb_mem_c)              b_sel_c = SEL_MEM;
`ifdef WB_BYPASS_EN
    else if (mb_wb_c)               b_sel_c = SEL_WB;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
`ifdef WB_BYPASS_EN
      wb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
`ifdef WB_BYPASS_EN
      wb_q    <= wb_d;
`endif
    end
  end

  // Next state, slot advance and sequencing outputs; flush > BUSY > load-use > issue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_d      = ex_q;
    mem_d.rw  = ex_q.rw;
    mem_d.wr  = ex_q.wr;
`ifdef WB_BYPASS_EN
    wb_d      = mem_q;
`endif
    issue     = 1'b0;
    stall     = 1'b0;
    ex_busy   = (state_q == BUSY);
    fwd_a_sel = a_sel_c;
    fwd_b_sel = b_sel_c;

    if (flush) begin
      ex_d    = '0;
      state_d = RUN;
      cnt_d   = '0;
      // An aborted multi-cycle op must not reach MEM.
      if (state_q == BUSY) mem_d = '0;
    end else if (state_q == BUSY) begin
      stall = 1'b1;
      mem_d = '0;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) state_d = RUN;
    end else begin
      stall = load_use_c;
      issue = dec_valid && !load_use_c && !reset;
      if (issue) begin
        ex_d.rw   = RW_dec;
        ex_d.wr   = dec_wr_en;
        ex_d.load = dec_is_load;
      end else begin
        ex_d = '0;
      end
      if (issue && dec_multi) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(MUL_CYCLES - 1);
      end
    end

    if (reset) begin
      issue     = 1'b0;
      stall     = 1'b0;
      ex_busy   = 1'b0;
      fwd_a_sel = SEL_RF;
      fwd_b_sel = SEL_RF;
    end
  end

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed bench for ex_hazard_controller (MUL_CYCLES=4); distance-3 expectation follows WB_BYPASS_EN.
module tb_ex_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, RW_dec;
  logic       dec_rs1_used, dec_rs2_used, dec_wr_en, dec_is_load, dec_multi, flush;
  logic       issue, stall, ex_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int total = 0;
  int bad   = 0;

`ifdef WB_BYPASS_EN
  localparam logic [1:0] DIST3_SEL = 2'b11;
`else
  localparam logic [1:0] DIST3_SEL = 2'b00;
`endif

  ex_hazard_controller #(.MUL_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .RW_dec(RW_dec), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load),
    .dec_multi(dec_multi), .flush(flush),
    .issue(issue), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  task automatic set_dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rw, input logic wr,
                         input logic ld, input logic mul);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    RW_dec = rw; dec_wr_en = wr; dec_is_load = ld; dec_multi = mul; flush = 1'b0;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    RW_dec = '0; dec_wr_en = 1'b0; dec_is_load = 1'b0; dec_multi = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic test_reset();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    step();
    #1;
    total++; if (issue !== 1'b0) begin bad++; $display("FAIL reset_issue: got=%b exp=0", issue); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got=%b exp=0", stall); end
    total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", ex_busy); end
    total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      bad++; $display("FAIL reset_sel: got=%b/%b exp=00/00", fwd_a_sel, fwd_b_sel);
    end
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_issue1: got=%b exp=1", issue); end
    total++; if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL b2b_sel1: got=%b exp=00", fwd_a_sel); end
    step();
    set_dec(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (fwd_a_sel !== 2'b01) begin bad++; $display("FAIL b2b_fwd_a: got=%b exp=01", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'b00) begin bad++; $display("FAIL b2b_fwd_b: got=%b exp=00", fwd_b_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall: got=%b exp=0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_issue2: got=%b exp=1", issue); end
    step();
    drain();
  endtask

  task automatic test_load_use();
    set_dec(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    step();
    set_dec(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got=%b exp=1", stall); end
    total++; if (issue !== 1'b0) begin bad++; $display("FAIL lu_issue: got=%b exp=0", issue); end
    step();
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall2: got=%b exp=0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL lu_issue2: got=%b exp=1", issue); end
    total++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      bad++; $display("FAIL lu_fwd: got=%b/%b exp=10/10", fwd_a_sel, fwd_b_sel);
    end
    step();
    drain();
  endtask

  task automatic test_multi();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL mul_issue: got=%b exp=1", issue); end
    step();
    set_dec(5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ex_busy !== 1'b1 || stall !== 1'b1 || issue !== 1'b0) begin
        bad++; $display("FAIL mul_busy%0d: got busy=%b stall=%b issue=%b exp 1/1/0", i, ex_busy, stall, issue);
      end
      step();
    end
    #1;
    total++; if (ex_busy !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL mul_release: got busy=%b stall=%b exp 0/0", ex_busy, stall);
    end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL mul_dep_issue: got=%b exp=1", issue); end
    total++; if (fwd_a_sel !== 2'b01) begin bad++; $display("FAIL mul_dep_fwd: got=%b exp=01", fwd_a_sel); end
    step();
    drain();
  endtask

  task automatic test_load_then_multi();
    set_dec(5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    step();
    set_dec(5'd11, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    #1;
    total++; if (stall !== 1'b1 || issue !== 1'b0 || ex_busy !== 1'b0) begin
      bad++; $display("FAIL lm_stall: got stall=%b issue=%b busy=%b exp 1/0/0", stall, issue, ex_busy);
    end
    step();
    #1;
    total++; if (issue !== 1'b1 || fwd_a_sel !== 2'b10) begin
      bad++; $display("FAIL lm_issue: got issue=%b sel=%b exp 1/10", issue, fwd_a_sel);
    end
    step();
    idle();
    #1;
    total++; if (ex_busy !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL lm_busy: got busy=%b stall=%b exp 1/1", ex_busy, stall);
    end
    drain();
  endtask

  task automatic test_r0_and_distance3();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    set_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      bad++; $display("FAIL r0_fwd: got=%b/%b exp=00/00", fwd_a_sel, fwd_b_sel);
    end
    total++; if (stall !== 1'b0 || issue !== 1'b1) begin
      bad++; $display("FAIL r0_stall: got stall=%b issue=%b exp 0/1", stall, issue);
    end
    step();
    drain();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0);
    step();
    set_dec(5'd2, 1'b1, 5'd3, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0);
    step();
    set_dec(5'd4, 1'b1, 5'd0, 1'b0, 5'd22, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (fwd_a_sel !== DIST3_SEL) begin
      bad++; $display("FAIL dist3_fwd: got=%b exp=%b", fwd_a_sel, DIST3_SEL);
    end
    total++; if (stall !== 1'b0 || issue !== 1'b1) begin
      bad++; $display("FAIL dist3_issue: got stall=%b issue=%b exp 0/1", stall, issue);
    end
    step();
    drain();
  endtask

  task automatic test_flush_busy();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
    step();
    idle();
    #1;
    total++; if (ex_busy !== 1'b1) begin bad++; $display("FAIL fl_busy: got=%b exp=1", ex_busy); end
    step();
    idle();
    flush = 1'b1;
    #1;
    total++; if (issue !== 1'b0) begin bad++; $display("FAIL fl_issue: got=%b exp=0", issue); end
    step();
    set_dec(5'd13, 1'b1, 5'd0, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (ex_busy !== 1'b0) begin bad++; $display("FAIL fl_busy_fall: got=%b exp=0", ex_busy); end
    total++; if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL fl_fwd: got=%b exp=00", fwd_a_sel); end
    total++; if (stall !== 1'b0 || issue !== 1'b1) begin
      bad++; $display("FAIL fl_issue2: got stall=%b issue=%b exp 0/1", stall, issue);
    end
    step();
    drain();
  endtask

  task automatic test_async_reset();
    set_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1);
    step();
    set_dec(5'd14, 1'b1, 5'd0, 1'b0, 5'd18, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (ex_busy !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL ar_busy_pre: got busy=%b stall=%b exp 1/1", ex_busy, stall);
    end
    #1 reset = 1'b1;
    #1;
    total++; if (issue !== 1'b0 || stall !== 1'b0 || ex_busy !== 1'b0 || fwd_a_sel !== 2'b00) begin
      bad++; $display("FAIL ar_busy_rst: got issue=%b stall=%b busy=%b sel=%b exp 0/0/0/00", issue, stall, ex_busy, fwd_a_sel);
    end
    reset = 1'b0;
    #1;
    total++; if (issue !== 1'b1 || stall !== 1'b0 || fwd_a_sel !== 2'b00) begin
      bad++; $display("FAIL ar_busy_after: got issue=%b stall=%b sel=%b exp 1/0/00", issue, stall, fwd_a_sel);
    end
    step();
    drain();
    set_dec(5'd1, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0);
    step();
    set_dec(5'd15, 1'b1, 5'd15, 1'b1, 5'd19, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ar_lu_pre: got=%b exp=1", stall); end
    #1 reset = 1'b1;
    #1;
    total++; if (issue !== 1'b0 || stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      bad++; $display("FAIL ar_lu_rst: got issue=%b stall=%b sel=%b/%b exp 0/0/00/00", issue, stall, fwd_a_sel, fwd_b_sel);
    end
    reset = 1'b0;
    #1;
    total++; if (issue !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL ar_lu_after: got issue=%b stall=%b exp 1/0", issue, stall);
    end
    step();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_multi();
    test_load_then_multi();
    test_r0_and_distance3();
    test_flush_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
